// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: load/store request, response and memory bus between pipeline, LSU and memory
interface lsu_mem_port_if #(parameter int DATA_W = 64);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_done;
  logic              mem_wr_done;
  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_rd_data, mem_rd_done, mem_wr_done,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );
  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_rd_data, mem_rd_done, mem_wr_done,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store initiator with RMW for sub-width stores and done timeout
// Define LSU_ALIGN_CHECK_EN to reject misaligned requests with an error response and no memory access.
module lsu_mem_port #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  lsu_mem_port_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_RD_WAIT, WR_WAIT} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mask;
  logic              sign_bit;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;
  // a shift by the full width yields 0, so the dword mask wraps to all ones
  assign mask       = (DATA_W'(1) << (8 << size_q)) - DATA_W'(1);
  assign sign_bit   = |(bus.mem_rd_data & mask & ~(mask >> 1));
  assign load_data  = (bus.mem_rd_data & mask) | ((sgn_q & sign_bit) ? ~mask : '0);
  assign merge_data = (bus.mem_rd_data & ~mask) | (wdata_q & mask);
`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |(bus.req_addr & ((DATA_W'(1) << bus.req_size) - DATA_W'(1)));
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      size_q          <= '0;
      sgn_q           <= 1'b0;
      wdata_q         <= '0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
    end else begin
      bus.mem_rd_en  <= 1'b0;
      bus.mem_wr_en  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            size_q       <= bus.req_size;
            sgn_q        <= bus.req_signed;
            wdata_q      <= bus.req_wdata;
            bus.mem_addr <= bus.req_addr;
            cnt          <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            if (misaligned) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
            end else
`endif
            begin
              bus.req_ready <= 1'b0;
              if (bus.req_we && bus.req_size == 2'd3) begin
                state           <= WR_WAIT;
                bus.mem_wr_en   <= 1'b1;
                bus.mem_wr_data <= bus.req_wdata;
              end else begin
                state         <= bus.req_we ? RMW_RD_WAIT : RD_WAIT;
                bus.mem_rd_en <= 1'b1;
              end
            end
          end
        end
        default: begin
          if (state != WR_WAIT && bus.mem_rd_done) begin
            cnt <= '0;
            if (state == RMW_RD_WAIT) begin
              state           <= WR_WAIT;
              bus.mem_wr_en   <= 1'b1;
              bus.mem_wr_data <= merge_data;
            end else begin
              state          <= IDLE;
              bus.req_ready  <= 1'b1;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= load_data;
            end
          end else if (state == WR_WAIT && bus.mem_wr_done) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b1;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed checks of lsu_mem_port against a byte memory that completes
// reads in the strobe cycle and writes one cycle after the strobe.
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic silent = 1'b0;
  logic late_rd = 1'b0;
  logic late_wr = 1'b0;
  logic wr_done_r = 1'b0;
  logic [7:0] mem [0:255];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both = 0;
  logic [63:0] last_wr = '0;
  int errors = 0;
  int checks = 0;
  int lat;
  logic [63:0] rdata;
  logic err;
  int rd0;
  int wr0;

  lsu_mem_port_if #(.DATA_W(64)) bus ();
  lsu_mem_port #(.DATA_W(64), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always_comb begin
    bus.mem_rd_data = '0;
    for (int i = 0; i < 8; i++) bus.mem_rd_data[8*i +: 8] = mem[bus.mem_addr[7:0] + 8'(i)];
  end
  assign bus.mem_rd_done = (bus.mem_rd_en & ~silent) | late_rd;
  assign bus.mem_wr_done = wr_done_r | late_wr;

  always @(posedge clk) begin
    wr_done_r <= 1'b0;
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem[8'h10] <= 8'h80;
      for (int i = 1; i < 8; i++) mem[8'h10 + i] <= 8'(i);
    end else if (bus.mem_wr_en) begin
      for (int i = 0; i < 8; i++) mem[bus.mem_addr[7:0] + 8'(i)] <= bus.mem_wr_data[8*i +: 8];
      wr_done_r <= ~silent;
      wr_cnt++;
      last_wr <= bus.mem_wr_data;
    end
    if (bus.mem_rd_en) rd_cnt++;
    if (bus.mem_rd_en && bus.mem_wr_en) both++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic we, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                     input logic [63:0] wd, input bit poke_wr,
                     output int l, output logic [63:0] rd, output logic e);
    chk("ready_before_req", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    step();
    bus.req_valid = 1'b0;
    l = 0;
    while (!bus.resp_valid && l < 40) begin
      late_wr = poke_wr && l == 1;
      step();
      l++;
    end
    late_wr = 1'b0;
    rd = bus.resp_rdata;
    e = bus.resp_err;
    step();
    chk("resp_one_cycle", 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("rst_addr", bus.mem_addr, 64'd0);

    run(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 1'b0, lat, rdata, err);
    chk("ld_d_lat", 64'(lat), 64'd1);
    chk("ld_d_data", rdata, 64'h0706050403020180);
    chk("ld_d_err", 64'(err), 64'd0);
    run(1'b0, 2'd0, 1'b1, 64'h10, 64'h0, 1'b0, lat, rdata, err);
    chk("ld_sb_data", rdata, 64'hFFFFFFFFFFFFFF80);
    run(1'b0, 2'd0, 1'b0, 64'h10, 64'h0, 1'b0, lat, rdata, err);
    chk("ld_ub_data", rdata, 64'h80);
    run(1'b0, 2'd1, 1'b1, 64'h10, 64'h0, 1'b0, lat, rdata, err);
    chk("ld_sh_data", rdata, 64'h0180);
    run(1'b0, 2'd2, 1'b1, 64'h14, 64'h0, 1'b0, lat, rdata, err);
    chk("ld_sw_data", rdata, 64'h07060504);

    rd0 = rd_cnt; wr0 = wr_cnt;
    run(1'b1, 2'd1, 1'b0, 64'h10, 64'h123456789ABCBEEF, 1'b0, lat, rdata, err);
    chk("st_h_lat", 64'(lat), 64'd3);
    chk("st_h_reads", 64'(rd_cnt - rd0), 64'd1);
    chk("st_h_writes", 64'(wr_cnt - wr0), 64'd1);
    chk("st_h_wdata", last_wr, 64'h070605040302BEEF);
    chk("st_h_rdata", rdata, 64'h0);
    chk("st_h_err", 64'(err), 64'd0);
    run(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 1'b0, lat, rdata, err);
    chk("st_h_reload", rdata, 64'h070605040302BEEF);

    rd0 = rd_cnt;
    run(1'b1, 2'd3, 1'b0, 64'h20, 64'h1122334455667788, 1'b0, lat, rdata, err);
    chk("st_d_lat", 64'(lat), 64'd2);
    chk("st_d_reads", 64'(rd_cnt - rd0), 64'd0);
    chk("st_d_wdata", last_wr, 64'h1122334455667788);

    silent = 1'b1;
    wr0 = wr_cnt;
    run(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 1'b1, lat, rdata, err);
    chk("to_lat", 64'(lat), 64'd16);
    chk("to_err", 64'(err), 64'd1);
    chk("to_rdata", rdata, 64'h0);
    late_rd = 1'b1;
    step();
    late_rd = 1'b0;
    chk("late_done_resp", 64'(bus.resp_valid), 64'd0);
    chk("late_done_ready", 64'(bus.req_ready), 64'd1);
    run(1'b1, 2'd0, 1'b0, 64'h30, 64'h5A, 1'b0, lat, rdata, err);
    chk("to_rmw_err", 64'(err), 64'd1);
    chk("to_rmw_no_write", 64'(wr_cnt - wr0), 64'd0);

    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_addr = 64'h30; bus.req_wdata = 64'hA5;
    step();
    bus.req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd1);
    chk("mid_rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("mid_rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("mid_rst_resp", 64'(bus.resp_valid), 64'd0);
    silent = 1'b0;
    step();
    chk("mid_rst_resp2", 64'(bus.resp_valid), 64'd0);
    run(1'b1, 2'd3, 1'b0, 64'h20, 64'hCAFEF00DDEADBEEF, 1'b0, lat, rdata, err);
    chk("post_rst_st_lat", 64'(lat), 64'd2);
    chk("post_rst_st_err", 64'(err), 64'd0);
    run(1'b0, 2'd3, 1'b0, 64'h20, 64'h0, 1'b0, lat, rdata, err);
    chk("post_rst_reload", rdata, 64'hCAFEF00DDEADBEEF);

    rd0 = rd_cnt;
    run(1'b0, 2'd2, 1'b0, 64'h12, 64'h0, 1'b0, lat, rdata, err);
`ifdef LSU_ALIGN_CHECK_EN
    chk("mis_lat", 64'(lat), 64'd0);
    chk("mis_err", 64'(err), 64'd1);
    chk("mis_rdata", rdata, 64'h0);
    chk("mis_no_read", 64'(rd_cnt - rd0), 64'd0);
`else
    chk("mis_lat", 64'(lat), 64'd1);
    chk("mis_err", 64'(err), 64'd0);
    chk("mis_rdata", rdata, 64'h05040302);
    chk("mis_one_read", 64'(rd_cnt - rd0), 64'd1);
`endif
    chk("strobes_exclusive", 64'(both), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Initiator side of the byte-addressed core memory interface (rd_en/wr_en strobes, rd_done/wr_done completions).
- Sits between the pipeline's load/store stage and the memory block.
- Accepts one load or store of 1/2/4/8 bytes at a time, with sign/zero extension on loads.
- Performs read-modify-write for sub-width stores, because a memory write always covers DATA_W/8 bytes at addr..addr+BYTES-1.
- Reports completion or timeout error.

Parameters:
- DATA_W, 64, data and address width; BYTES = DATA_W/8.
- TIMEOUT, 16, wait-state cycles before a missing done is declared an error (>=2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1=store, 0=load
- req_size  input  2  0=byte, 1=half, 2=word, 3=dword
- req_signed  input  1  sign-extend load result
- req_addr  input  DATA_W  byte address
- req_wdata  input  DATA_W  store data, low bytes used
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  valid with resp_valid; timeout (or misalign, see option)
- resp_rdata  output  DATA_W  load result; 0 for stores and errors
- mem_rd_en  output  1  read strobe to memory
- mem_wr_en  output  1  write strobe to memory
- mem_addr  output  DATA_W  address to memory
- mem_wr_data  output  DATA_W  write data to memory
- mem_rd_data  input  DATA_W  read data from memory
- mem_rd_done  input  1  read completion pulse
- mem_wr_done  input  1  write completion pulse

Behaviour:
- Reset, synchronous:
  - state=IDLE.
  - req_ready=1 after reset; all other outputs 0.
  - Timeout counter 0.
- States: IDLE, RD_WAIT, RMW_RD_WAIT, WR_WAIT.
- req_ready = (state==IDLE). Accept when req_valid & req_ready. Request fields are captured at acceptance.
- All outputs are registered.
- mem_rd_en and mem_wr_en are exactly one-cycle pulses, never both high together.
- mem_addr is held at the captured address until the return to IDLE.
- Load, IDLE->RD_WAIT:
  - Accept edge E0 sets mem_rd_en=1.
  - On the edge where mem_rd_done=1 is sampled: extract low 8<<req_size bits of mem_rd_data.
  - Sign-extend if req_signed, else zero-extend.
  - Set resp_valid=1, resp_err=0, go to IDLE.
  - With a 1-cycle memory, resp_valid is high in the 2nd cycle after acceptance.
- Store, size 3, IDLE->WR_WAIT:
  - Accept edge sets mem_wr_en=1, mem_wr_data=req_wdata.
  - On mem_wr_done: resp_valid=1, resp_rdata=0, go to IDLE.
- Store, size 0..2, IDLE->RMW_RD_WAIT->WR_WAIT:
  - Accept edge issues mem_rd_en.
  - On mem_rd_done: mem_wr_data = mem_rd_data with its low 1<<req_size bytes replaced by the low bytes of req_wdata; upper bytes are preserved.
  - Pulse mem_wr_en on the same edge and go to WR_WAIT.
  - Completion as for a dword store; response in the 4th cycle after acceptance.
- Timeout:
  - The counter clears on entry to each wait state and increments each cycle without the expected done.
  - When it reaches TIMEOUT: resp_valid=1, resp_err=1, resp_rdata=0, go to IDLE, no write issued.
- Done pulses:
  - A done arriving in IDLE, or of the wrong kind (wr_done while waiting for a read, or the reverse), is ignored.
  - A late done after a timeout is therefore dropped.
- resp_valid and resp_err are cleared each cycle unless set. No response backpressure.
- Back-to-back: a new request may be accepted in the cycle resp_valid is high.
- Reset mid-operation: return to IDLE, drop the strobes, discard the captured request. No resp_valid is produced for the aborted request.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - A request whose address is not a multiple of 1<<req_size issues no memory access.
  - resp_valid=1 and resp_err=1 are produced on the edge after acceptance, with resp_rdata=0.
- Undefined: misaligned accesses proceed normally; the memory is byte-addressed.

Test Plan:
- Memory pre-loaded with bytes 0x80,0x01..0x07 at 0x10. Load dword 0x10 -> resp_rdata=0x0706050403020180 two cycles after accept, resp_err=0.
- Same memory, signed byte load at 0x10 -> 0xFFFFFFFFFFFFFF80. Unsigned byte load -> 0x80.
- Half store 0xBEEF at 0x10 -> one read then one write with mem_wr_data=0x070605040302BEEF; resp 4 cycles after accept. Reload dword confirms bytes 2..7 unchanged.
- Memory model never asserts done, TIMEOUT=16 -> resp_valid with resp_err=1 after 16 wait cycles. A late rd_done is ignored and req_ready=1.
- rst pulsed while in RMW_RD_WAIT -> next cycle req_ready=1, no strobes, no resp_valid. A following dword store to 0x20 completes normally.
- With LSU_ALIGN_CHECK_EN, word load at 0x12 -> resp_err=1 one cycle after accept, mem_rd_en never asserted. Without the macro, the same load returns the bytes at 0x12..0x15.
